// File: rtl/bg_index_pkg.sv
// rtl/bg_index_pkg.sv - shared widths and scan state encoding for the tile index reader
// Purpose: common localparams and the scan FSM state type.
package bg_index_pkg;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int TILE_W     = 8;
  localparam int COUNT_W    = 7;
  localparam int BYTE_CNT_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/bg_word_fifo.sv
// rtl/bg_word_fifo.sv - synchronous show-ahead word buffer
// Purpose: DEPTH x DATA_W FIFO; head word visible on rd_data_o whenever empty_o is low.
// Ports: clk_i/rst_i clock and sync active-high reset; wr_en_i/wr_data_i push;
//        rd_en_i pop; rd_data_o head word; full_o/empty_o/count_o occupancy.
module bg_word_fifo
  import bg_index_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_wr;
  logic              do_rd;

  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/bg_index_reader.sv
// rtl/bg_index_reader.sv - scans index words over Avalon-MM and streams them out as bytes
// Purpose: on start, read word_count words from base_addr (wrapping), buffer them and
//          emit each as four bytes, LSB first, with tile_last on the final byte.
// Ports: clk_clk/reset_reset clock and sync reset; start/base_addr/word_count request;
//        busy/done status; m_* Avalon-MM read master; tile_* byte stream with ready.
module bg_index_reader
  import bg_index_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [COUNT_W-1:0] word_count,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  m_address,
  output logic               m_chipselect,
  output logic               m_clken,
  output logic               m_write,
  output logic [3:0]         m_byteenable,
  output logic [DATA_W-1:0]  m_writedata,
  input  logic [DATA_W-1:0]  m_readdata,
  output logic               tile_valid,
  output logic [TILE_W-1:0]  tile_data,
  output logic               tile_last,
  input  logic               tile_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [COUNT_W-1:0]      issue_left_q, issue_left_d;
  logic [BYTE_CNT_W-1:0]   bytes_left_q, bytes_left_d;
  logic [1:0]              byte_sel_q, byte_sel_d;
  logic [CW-1:0]           inflight_q, inflight_d;
  logic [READ_LATENCY-1:0] pipe_q;
  logic                    done_q, done_d;

  logic              issue, ret, xfer, pop, room;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [SW-1:0]     occupancy;
  logic [TILE_W-1:0] tile_byte;

  bg_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_clk),
    .rst_i     (reset_reset),
    .wr_en_i   (ret),
    .wr_data_i (m_readdata),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Reads in flight have already claimed a buffer slot, so the issue decision
  // counts them with the stored words to keep the FIFO from ever overflowing.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign room      = !fifo_full && (occupancy < SW'(FIFO_DEPTH));
  assign ret       = pipe_q[READ_LATENCY-1];
  assign tile_valid = (state_q != IDLE) && !fifo_empty;
  assign xfer      = tile_valid && tile_ready;

  always_comb begin
    tile_byte = '0;
    case (byte_sel_q)
      2'd0: tile_byte = fifo_rdata[7:0];
      2'd1: tile_byte = fifo_rdata[15:8];
      2'd2: tile_byte = fifo_rdata[23:16];
      2'd3: tile_byte = fifo_rdata[31:24];
      default: tile_byte = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    bytes_left_d = bytes_left_q;
    byte_sel_d   = byte_sel_q;
    done_d       = 1'b0;
    issue        = 1'b0;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = ISSUE;
            addr_d       = base_addr;
            issue_left_d = word_count;
            bytes_left_d = {word_count, 2'b00};
            byte_sel_d   = 2'd0;
          end
        end
      end
      ISSUE: begin
        if (room) begin
          issue        = 1'b1;
          addr_d       = addr_q + ADDR_W'(1);
          issue_left_d = issue_left_q - COUNT_W'(1);
          if (issue_left_q == COUNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && bytes_left_q == BYTE_CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      bytes_left_d = bytes_left_q - BYTE_CNT_W'(1);
      byte_sel_d   = byte_sel_q + 2'd1;
      pop          = (byte_sel_q == 2'd3);
    end
  end

  assign inflight_d = inflight_q + CW'(issue) - CW'(ret);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      bytes_left_q <= '0;
      byte_sel_q   <= '0;
      inflight_q   <= '0;
      pipe_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      bytes_left_q <= bytes_left_d;
      byte_sel_q   <= byte_sel_d;
      inflight_q   <= inflight_d;
      done_q       <= done_d;
      // Read-return tracker: clearing it on reset drops any data still in flight.
      pipe_q[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign m_address    = addr_q;
  assign m_chipselect = issue;
  assign m_clken      = 1'b1;
  assign m_write      = 1'b0;
  assign m_byteenable = 4'hF;
  assign m_writedata  = '0;
  assign tile_data    = tile_valid ? tile_byte : '0;
  assign tile_last    = tile_valid && (bytes_left_q == BYTE_CNT_W'(1));

endmodule

// File: tb/tb_bg_index_reader.sv
// tb/tb_bg_index_reader.sv - self-checking bench for bg_index_reader
module tb_bg_index_reader;

  localparam int DEPTH = 4;
  localparam int RL    = 1;

  logic        clk = 1'b0;
  logic        rst, start, tile_ready;
  logic [5:0]  base_addr;
  logic [6:0]  word_count;
  logic        busy, done, m_chipselect, m_clken, m_write;
  logic [5:0]  m_address;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata, m_readdata;
  logic        tile_valid, tile_last;
  logic [7:0]  tile_data;

  always #5 clk = ~clk;

  bg_index_reader #(.FIFO_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk_clk(clk), .reset_reset(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .m_address(m_address),
    .m_chipselect(m_chipselect), .m_clken(m_clken), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .tile_valid(tile_valid), .tile_data(tile_data), .tile_last(tile_last),
    .tile_ready(tile_ready)
  );

  // Index memory slave with fixed read latency
  logic [31:0] mem [64];
  logic [31:0] dpipe [RL];
  always @(posedge clk) begin
    dpipe[0] <= m_chipselect ? mem[m_address] : 32'hDEAD_BEEF;
    for (int i = 1; i < RL; i++) dpipe[i] <= dpipe[i-1];
  end
  assign m_readdata = dpipe[RL-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int issue_cnt, byte_cnt, done_cnt, max_out, last_cyc, done_cyc;
  bit done_busy_bad;
  logic [7:0] got_b[$];
  bit         got_l[$];
  logic [5:0] got_a[$];
  logic       pv, pr, pl;
  logic [7:0] pd;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_chipselect) begin
        issue_cnt++;
        got_a.push_back(m_address);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy) done_busy_bad = 1'b1;
      end
      if (pv && !pr) begin
        checks++;
        if (tile_valid !== 1'b1 || tile_data !== pd || tile_last !== pl) begin
          errors++;
          $display("FAIL hold_stable: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                   tile_valid, tile_data, tile_last, pd, pl);
        end
      end
      if (tile_valid && tile_ready) begin
        got_b.push_back(tile_data);
        got_l.push_back(tile_last);
        byte_cnt++;
        if (tile_last) last_cyc = cyc;
      end
      if (issue_cnt - byte_cnt / 4 > max_out) max_out = issue_cnt - byte_cnt / 4;
      pv = tile_valid; pr = tile_ready; pd = tile_data; pl = tile_last;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic clear_mon();
    issue_cnt = 0; byte_cnt = 0; done_cnt = 0; max_out = 0;
    last_cyc = -100; done_cyc = -200; done_busy_bad = 1'b0;
    got_b.delete(); got_l.delete(); got_a.delete();
  endtask

  function automatic logic [7:0] exp_byte(input int base, input int i);
    logic [31:0] w;
    w = mem[(base + i / 4) % 64];
    return 8'(w >> (8 * (i % 4)));
  endfunction

  task automatic randomize_mem();
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low 20 cycles then high
  task automatic run_scan(input string name, input int base, input int n, input int mode, input bit dbl);
    int k, bad;
    clear_mon();
    tile_ready = (mode != 2);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'(base); word_count = 7'(n);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_rise: got %b expected 1", name, busy); end
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      case (mode)
        0: tile_ready = 1'b1;
        1: tile_ready = 1'($urandom_range(0, 1));
        default: tile_ready = (k >= 20);
      endcase
      if (dbl && k == 3) begin
        start = 1'b1; base_addr = 6'(base + 5); word_count = 7'd3;
      end else start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0; tile_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL %s done_count: got %0d expected 1", name, done_cnt); end
    checks++;
    if (byte_cnt != 4 * n) begin errors++; $display("FAIL %s byte_count: got %0d expected %0d", name, byte_cnt, 4 * n); end
    checks++;
    if (issue_cnt != n) begin errors++; $display("FAIL %s read_count: got %0d expected %0d", name, issue_cnt, n); end
    bad = 0;
    for (int i = 0; i < got_b.size() && i < 4 * n; i++) begin
      if (got_b[i] !== exp_byte(base, i) || got_l[i] != (i == 4 * n - 1)) begin
        if (bad == 0)
          $display("FAIL %s byte[%0d]: got data=%h last=%b expected data=%h last=%b",
                   name, i, got_b[i], got_l[i], exp_byte(base, i), (i == 4 * n - 1));
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    bad = 0;
    for (int i = 0; i < got_a.size() && i < n; i++)
      if (got_a[i] !== 6'((base + i) % 64)) begin
        if (bad == 0)
          $display("FAIL %s addr[%0d]: got %0d expected %0d", name, i, got_a[i], (base + i) % 64);
        bad++;
      end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (done_cyc - last_cyc != 1) begin
      errors++; $display("FAIL %s done_timing: got %0d cycles after last expected 1", name, done_cyc - last_cyc);
    end
    checks++;
    if (done_busy_bad) begin errors++; $display("FAIL %s busy_at_done: got 1 expected 0", name); end
    checks++;
    if (max_out > DEPTH) begin errors++; $display("FAIL %s outstanding: got %0d expected <= %0d", name, max_out, DEPTH); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_end: got %b expected 0", name, busy); end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tile_valid !== 1'b0 || tile_last !== 1'b0 ||
        m_chipselect !== 1'b0 || m_address !== 6'd0 || tile_data !== 8'd0) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b valid=%b last=%b cs=%b addr=%0d data=%h expected all 0",
               name, busy, done, tile_valid, tile_last, m_chipselect, m_address, tile_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_state");
    checks++;
    if (m_clken !== 1'b1 || m_write !== 1'b0 || m_byteenable !== 4'hF || m_writedata !== 32'd0) begin
      errors++;
      $display("FAIL constants: got clken=%b write=%b be=%h wdata=%h expected 1 0 f 0",
               m_clken, m_write, m_byteenable, m_writedata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_values("post_reset_idle");
  endtask

  task automatic test_example();
    randomize_mem();
    mem[0] = 32'h4433_2211;
    mem[1] = 32'h8877_6655;
    run_scan("example", 0, 2, 0, 1'b0);
    checks++;
    if (got_b.size() != 8 || got_b[0] !== 8'h11 || got_b[7] !== 8'h88 || got_l[7] != 1'b1) begin
      errors++;
      $display("FAIL example_bytes: got %0d bytes first=%h expected 8 bytes 11..88",
               got_b.size(), (got_b.size() > 0) ? got_b[0] : 8'hxx);
    end
  endtask

  task automatic test_wrap();
    randomize_mem();
    run_scan("wrap", 62, 4, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    randomize_mem();
    run_scan("backpressure", $urandom_range(0, 63), 64, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      randomize_mem();
      run_scan("random", $urandom_range(0, 63), $urandom_range(1, 20), 1, 1'b0);
    end
  endtask

  task automatic test_zero();
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd9; word_count = 7'd0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done: got done=%b busy=%b expected done=1 busy=0", done, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_after: got done=%b busy=%b expected 0 0", done, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (issue_cnt != 0) begin errors++; $display("FAIL zero_reads: got %0d expected 0", issue_cnt); end
  endtask

  task automatic test_back_to_back_start();
    randomize_mem();
    run_scan("double_start", $urandom_range(0, 63), 10, 0, 1'b1);
  endtask

  task automatic test_reset_mid_scan();
    randomize_mem();
    clear_mon();
    tile_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd20; word_count = 7'd64;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    tile_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_values("mid_scan_reset");
    run_scan("after_reset", $urandom_range(0, 63), 1, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; tile_ready = 1'b1;
    randomize_mem();
    clear_mon();
    test_reset();
    test_example();
    test_wrap();
    test_backpressure();
    test_random();
    test_zero();
    test_back_to_back_start();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
